// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the two-channel packet arbiter pair (fifo_arb_tx /
// fifo_arb_rx): FSM state encoding, default header field masks, and the header
// decode helpers. Both sides call the same decode helpers, so they always agree
// on which channel a header selects and how many payload words follow it.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  // Header-decode state vs. payload-forwarding state
  typedef enum logic [0:0] {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_DWIDTH   = 8;
  localparam logic [31:0] DEF_SELMASK  = 32'h0000_0080;
  localparam logic [31:0] DEF_CNTMASK  = 32'h0000_0070;
  localparam int unsigned DEF_CNTSHIFT = 4;

  // Number of set bits in a field mask. This sizes the payload counter so it
  // can hold the largest count the header field can encode. An empty mask
  // still yields a 1-bit counter so that no zero-width vectors are created.
  function automatic int unsigned mask_width(input logic [31:0] mask);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) n = n + 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  // Channel select: any masked bit set -> channel 2, otherwise channel 1
  function automatic logic hdr_sel(input logic [31:0] hdr,
                                   input logic [31:0] selMask = DEF_SELMASK);
    return |(hdr & selMask);
  endfunction

  // Payload word count carried in the header
  function automatic logic [31:0] hdr_cnt(input logic [31:0] hdr,
                                          input logic [31:0] cntMask  = DEF_CNTMASK,
                                          input int unsigned cntShift = DEF_CNTSHIFT);
    return (hdr & cntMask) >> cntShift;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// -----------------------------------------------------------------------------
// fifo_skid2
// Two-entry buffer that sits after a FIFO with a one-cycle read latency. It
// absorbs words whose reads were already issued when the consumer stalls, so
// reads can be issued back-to-back without losing data.
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset (empties the buffer)
//   i_push       write i_pushData into the buffer this cycle
//   i_pushData   word to store
//   i_pop        consume the head word this cycle
//   o_headData   oldest stored word (meaningful when o_headValid)
//   o_headValid  buffer holds at least one word
//   o_occupancy  number of stored words (0..2)
// -----------------------------------------------------------------------------
module fifo_skid2 #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_pushData,
  input  logic              i_pop,
  output logic [DWIDTH-1:0] o_headData,
  output logic              o_headValid,
  output logic [1:0]        o_occupancy
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_count;
  logic              w_popOk;
  logic              w_pushOk;

  // A pop needs a stored word; a push needs a free slot, which a same-cycle
  // pop provides. The parent never violates either, but the guards keep the
  // pointers and the count consistent regardless.
  assign w_popOk  = i_pop && (r_count != 2'd0);
  assign w_pushOk = i_push && ((r_count != 2'd2) || w_popOk);

  // Circular two-slot storage with separate read/write pointers and a count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_popOk) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headData  = r_mem[r_rdPtr];
  assign o_headValid = (r_count != 2'd0);
  assign o_occupancy = r_count;

endmodule

// File: rtl/fifo_arb_rx.sv
// -----------------------------------------------------------------------------
// fifo_arb_rx
// Receive side of the two-channel packet arbiter. Pops a merged packet stream
// from a shared FIFO, decodes each header (channel select + payload count) and
// steers the header and its payload words to the channel 1 or channel 2 write
// port. A destination that is full stalls the whole stream (head-of-line
// blocking) without losing or reordering words.
//
// Optional build macro: FIFO_ARB_RX_STATS_EN adds per-channel completed-packet
// counters (c1_pkts, c2_pkts).
//
// Ports
//   CLK, RST                  clock, asynchronous active-high reset
//   fifo_rden                 pop request to the shared input FIFO
//   fifo_rdempty              input FIFO empty
//   fifo_rddata               input FIFO data, valid the cycle after fifo_rden
//   c1_wren/c1_wrdata         channel 1 write strobe / data (registered)
//   c1_wrfull                 channel 1 FIFO full
//   c2_wren/c2_wrdata/c2_wrfull  same for channel 2
//   busy                      packet in progress or words held in the skid buffer
//   c1_pkts, c2_pkts          (stats build only) packets completed per channel
// -----------------------------------------------------------------------------
module fifo_arb_rx
  import fifo_arb_pkg::*;
#(
  parameter int unsigned       DWIDTH   = DEF_DWIDTH,
  parameter logic [DWIDTH-1:0] SELMASK  = DWIDTH'(DEF_SELMASK),
  parameter logic [DWIDTH-1:0] CNTMASK  = DWIDTH'(DEF_CNTMASK),
  parameter int unsigned       CNTSHIFT = DEF_CNTSHIFT
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              fifo_rden,
  input  logic              fifo_rdempty,
  input  logic [DWIDTH-1:0] fifo_rddata,
  output logic              c1_wren,
  input  logic              c1_wrfull,
  output logic [DWIDTH-1:0] c1_wrdata,
  output logic              c2_wren,
  input  logic              c2_wrfull,
  output logic [DWIDTH-1:0] c2_wrdata,
  output logic              busy
`ifdef FIFO_ARB_RX_STATS_EN
  ,
  output logic [15:0]       c1_pkts,
  output logic [15:0]       c2_pkts
`endif
);

  localparam int unsigned       CWIDTH  = mask_width(32'(CNTMASK));
  localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);

  arb_state_t        r_state;
  arb_state_t        w_stateNext;
  logic              r_sel;
  logic              w_selNext;
  logic [CWIDTH-1:0] r_remCnt;
  logic [CWIDTH-1:0] w_remCntNext;
  logic              r_inflight;

  logic [DWIDTH-1:0] w_head;
  logic              w_headValid;
  logic [1:0]        w_occ;
  logic              w_hdrSel;
  logic [CWIDTH-1:0] w_hdrCnt;
  logic              w_fire;
  logic              w_fireSel;
  logic [2:0]        w_pending;

  // Words whose read was issued last cycle arrive on fifo_rddata now and go
  // straight into the skid buffer; the FSM only ever consumes the head.
  fifo_skid2 #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_push      (r_inflight),
    .i_pushData  (fifo_rddata),
    .i_pop       (w_fire),
    .o_headData  (w_head),
    .o_headValid (w_headValid),
    .o_occupancy (w_occ)
  );

  assign w_hdrSel = hdr_sel(32'(w_head), 32'(SELMASK));
  assign w_hdrCnt = CWIDTH'(hdr_cnt(32'(w_head), 32'(CNTMASK), CNTSHIFT));

  // Issue a read only if the word is guaranteed a skid slot when it lands:
  // stored words plus the read in flight, minus the word leaving this cycle,
  // must stay below two. Held low during reset so nothing is popped and lost.
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_fire};
  assign fifo_rden = !RST && !fifo_rdempty && (w_pending < 3'd2);

  assign busy = (r_state == ST_PAY) || w_headValid;

  // Next-state and forwarding decision. A word is forwarded (w_fire) when it
  // sits at the skid head and its destination is not full this cycle. In HDR
  // the destination comes from the header itself; in PAY from the latched
  // select. The count is latched as the header is forwarded.
  always_comb begin
    w_stateNext  = r_state;
    w_selNext    = r_sel;
    w_remCntNext = r_remCnt;
    w_fire       = 1'b0;
    w_fireSel    = r_sel;
    unique case (r_state)
      ST_HDR: begin
        if (w_headValid) begin
          w_fireSel = w_hdrSel;
          if (!(w_hdrSel ? c2_wrfull : c1_wrfull)) begin
            w_fire       = 1'b1;
            w_selNext    = w_hdrSel;
            w_remCntNext = w_hdrCnt;
            if (w_hdrCnt != '0) w_stateNext = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (w_headValid && !(r_sel ? c2_wrfull : c1_wrfull)) begin
          w_fire       = 1'b1;
          w_remCntNext = r_remCnt - CNT_ONE;
          if (r_remCnt == CNT_ONE) w_stateNext = ST_HDR;
        end
      end
      default: begin
        w_stateNext = ST_HDR;
      end
    endcase
  end

  // State, read-in-flight flag and the registered write ports. Write data
  // holds its last value between strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_HDR;
      r_sel      <= 1'b0;
      r_remCnt   <= '0;
      r_inflight <= 1'b0;
      c1_wren    <= 1'b0;
      c2_wren    <= 1'b0;
      c1_wrdata  <= '0;
      c2_wrdata  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_sel      <= w_selNext;
      r_remCnt   <= w_remCntNext;
      r_inflight <= fifo_rden;
      c1_wren    <= w_fire && !w_fireSel;
      c2_wren    <= w_fire && w_fireSel;
      if (w_fire && !w_fireSel) c1_wrdata <= w_head;
      if (w_fire && w_fireSel)  c2_wrdata <= w_head;
    end
  end

`ifdef FIFO_ARB_RX_STATS_EN
  logic w_lastWord;

  // The forwarded word closes a packet when it is a header with no payload
  // or the final payload word.
  assign w_lastWord = w_fire &&
                      (((r_state == ST_HDR) && (w_hdrCnt == '0)) ||
                       ((r_state == ST_PAY) && (r_remCnt == CNT_ONE)));

  // Completed-packet counters, wrapping naturally at 16 bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c1_pkts <= 16'd0;
      c2_pkts <= 16'd0;
    end else if (w_lastWord) begin
      if (w_fireSel) c2_pkts <= c2_pkts + 16'd1;
      else           c1_pkts <= c1_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_arb_rx.sv
// -----------------------------------------------------------------------------
// tb_fifo_arb_rx
// Bench for fifo_arb_rx. A queue models the shared input FIFO (one-cycle read
// latency); words written on each channel are captured into per-channel
// queues and compared against hand-written expectations. Build with
// FIFO_ARB_RX_STATS_EN defined to also check the packet counters.
// -----------------------------------------------------------------------------
module tb_fifo_arb_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       fifo_rden;
  logic       fifo_rdempty;
  logic [7:0] fifo_rddata;
  logic       c1_wren, c2_wren;
  logic       c1_wrfull, c2_wrfull;
  logic [7:0] c1_wrdata, c2_wrdata;
  logic       busy;
`ifdef FIFO_ARB_RX_STATS_EN
  logic [15:0] c1_pkts, c2_pkts;
`endif

  fifo_arb_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .fifo_rden    (fifo_rden),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rddata  (fifo_rddata),
    .c1_wren      (c1_wren),
    .c1_wrfull    (c1_wrfull),
    .c1_wrdata    (c1_wrdata),
    .c2_wren      (c2_wren),
    .c2_wrfull    (c2_wrfull),
    .c2_wrdata    (c2_wrdata),
    .busy         (busy)
`ifdef FIFO_ARB_RX_STATS_EN
    ,
    .c1_pkts      (c1_pkts),
    .c2_pkts      (c2_pkts)
`endif
  );

  always #5 CLK = ~CLK;

  // One table row per input word: the word and the channel it must land on
  typedef struct packed {
    logic [7:0] inWord;
    logic [1:0] expCh;
  } vec_t;

  vec_t       vecs [18];
  logic [7:0] srcQ [$];
  logic [7:0] c1Got [$];
  logic [7:0] c2Got [$];
  logic [7:0] expQ1 [$];
  logic [7:0] expQ2 [$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int firstWr = -1;
  int lastWr = -1;
  int bothErr = 0;
  int fullErr = 0;
  int emptyErr = 0;
  int underflowErr = 0;
  logic prevC1Full = 1'b0;
  logic prevC2Full = 1'b0;
  logic gapMode = 1'b0;
  logic gapPhase = 1'b0;
  logic randMode = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    srcQ.push_back(word);
    if (!gapMode) fifo_rdempty = 1'b0;
  endtask

  function automatic logic [31:0] gotAt(input int ch, input int idx);
    if (ch == 1) return (idx < c1Got.size()) ? {24'd0, c1Got[idx]} : 32'hDEAD;
    else         return (idx < c2Got.size()) ? {24'd0, c2Got[idx]} : 32'hDEAD;
  endfunction

  task automatic clearCapture();
    c1Got.delete();
    c2Got.delete();
    firstWr = -1;
    lastWr = -1;
  endtask

  // One clock: sample outputs and protocol at the falling edge, service the
  // read request, then drive next-cycle inputs just after the rising edge.
  task automatic stepCycle();
    logic       popNow;
    logic [7:0] popWord;
    popWord = 8'h00;
    @(negedge CLK);
    cycle++;
    if (c1_wren) c1Got.push_back(c1_wrdata);
    if (c2_wren) c2Got.push_back(c2_wrdata);
    if (c1_wren || c2_wren) begin
      if (firstWr < 0) firstWr = cycle;
      lastWr = cycle;
    end
    if (c1_wren && c2_wren) bothErr++;
    if ((c1_wren && prevC1Full) || (c2_wren && prevC2Full)) fullErr++;
    if (fifo_rden && fifo_rdempty) emptyErr++;
    prevC1Full = c1_wrfull;
    prevC2Full = c2_wrfull;
    popNow = fifo_rden;
    if (popNow) begin
      if (srcQ.size() > 0) popWord = srcQ.pop_front();
      else underflowErr++;
    end
    @(posedge CLK);
    #1;
    if (popNow) fifo_rddata = popWord;
    gapPhase = ~gapPhase;
    fifo_rdempty = (srcQ.size() == 0) || (gapMode && gapPhase);
    if (randMode) begin
      c1_wrfull = ($urandom_range(0, 3) == 0);
      c2_wrfull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) fifo_rdempty = 1'b1;
    end
  endtask

  task automatic runUntil(input int n1, input int n2, input int budget, input string name);
    int spent;
    spent = 0;
    while ((c1Got.size() < n1 || c2Got.size() < n2) && spent < budget) begin
      stepCycle();
      spent++;
    end
    checkOutput({name, " within budget"}, 32'(c1Got.size() >= n1 && c2Got.size() >= n2), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] bpWords [8];
    logic [7:0] gapWords [4];
    logic [7:0] hdr;
    logic [7:0] pay;
    int n1, n2, idx1, idx2, err1, err2, npk1, npk2;
`ifdef FIFO_ARB_RX_STATS_EN
    logic [15:0] base1, base2;
`endif

    vecs = '{
      '{8'h20, 2'd1}, '{8'hA1, 2'd1}, '{8'hA2, 2'd1},
      '{8'h90, 2'd2}, '{8'h11, 2'd2}, '{8'h00, 2'd1},
      '{8'hF3, 2'd2}, '{8'h81, 2'd2}, '{8'h02, 2'd2}, '{8'hFF, 2'd2},
      '{8'h04, 2'd2}, '{8'h85, 2'd2}, '{8'h06, 2'd2}, '{8'h07, 2'd2},
      '{8'h0F, 2'd1}, '{8'h8F, 2'd2}, '{8'h10, 2'd1}, '{8'h80, 2'd1}
    };
    bpWords  = '{8'h70, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    gapWords = '{8'h30, 8'hC1, 8'hC2, 8'hC3};

    fifo_rdempty = 1'b0;
    fifo_rddata  = 8'h00;
    c1_wrfull    = 1'b0;
    c2_wrfull    = 1'b0;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Reset values, with the input FIFO reporting data available
    checkOutput("reset fifo_rden", 32'(fifo_rden), 32'd0);
    checkOutput("reset c1_wren", 32'(c1_wren), 32'd0);
    checkOutput("reset c2_wren", 32'(c2_wren), 32'd0);
    checkOutput("reset c1_wrdata", 32'(c1_wrdata), 32'd0);
    checkOutput("reset c2_wrdata", 32'(c2_wrdata), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    RST = 1'b0;
    fifo_rdempty = 1'b1;
    stepCycle();

    // Table: packets back to back, each word checked on its channel in order
    clearCapture();
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].inWord);
      if (vecs[i].expCh == 2'd1) n1++;
      else n2++;
    end
    runUntil(n1, n2, 200, "table");
    repeat (4) stepCycle();
    idx1 = 0;
    idx2 = 0;
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].expCh == 2'd1) begin
        checkOutput($sformatf("vec%0d c1 word", i), gotAt(1, idx1), {24'd0, vecs[i].inWord});
        idx1++;
      end else begin
        checkOutput($sformatf("vec%0d c2 word", i), gotAt(2, idx2), {24'd0, vecs[i].inWord});
        idx2++;
      end
    end
    checkOutput("table c1 count", 32'(c1Got.size()), 32'(n1));
    checkOutput("table c2 count", 32'(c2Got.size()), 32'(n2));
    checkOutput("table throughput span", 32'(lastWr - firstWr), 32'd17);
    checkOutput("table busy idle", 32'(busy), 32'd0);

    // Backpressure: channel 1 full for 5 cycles mid-payload of a cnt=7 packet
    clearCapture();
    for (int i = 0; i < 8; i++) applyStimulus(bpWords[i]);
    runUntil(3, 0, 50, "bp prime");
    c1_wrfull = 1'b1;
    repeat (5) stepCycle();
    checkOutput("bp rden stops with skid full", 32'(fifo_rden), 32'd0);
    checkOutput("bp busy while stalled", 32'(busy), 32'd1);
    c1_wrfull = 1'b0;
    runUntil(8, 0, 50, "bp drain");
    repeat (3) stepCycle();
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("bp c1 word%0d", i), gotAt(1, i), {24'd0, bpWords[i]});
    checkOutput("bp c1 count", 32'(c1Got.size()), 32'd8);
    checkOutput("bp c2 count", 32'(c2Got.size()), 32'd0);

    // Input FIFO empty every other cycle during a cnt=3 packet
    clearCapture();
    gapMode = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(gapWords[i]);
    runUntil(4, 0, 60, "gap");
    repeat (4) stepCycle();
    gapMode = 1'b0;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("gap c1 word%0d", i), gotAt(1, i), {24'd0, gapWords[i]});
    checkOutput("gap c1 count", 32'(c1Got.size()), 32'd4);

    // Reset during payload after 2 of 5 payload words have gone out
    clearCapture();
    applyStimulus(8'hD5);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(8'hE0 + i));
    runUntil(0, 3, 40, "rst prime");
    RST = 1'b1;
    srcQ.delete();
    fifo_rdempty = 1'b0;
    #1;
    checkOutput("rst c2_wren", 32'(c2_wren), 32'd0);
    checkOutput("rst c2_wrdata", 32'(c2_wrdata), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst fifo_rden", 32'(fifo_rden), 32'd0);
    repeat (2) stepCycle();
    RST = 1'b0;
    applyStimulus(8'h10);
    applyStimulus(8'h55);
    runUntil(2, 3, 40, "rst recover");
    repeat (6) stepCycle();
    checkOutput("rst new hdr", gotAt(1, 0), 32'h10);
    checkOutput("rst new payload", gotAt(1, 1), 32'h55);
    checkOutput("rst c1 count", 32'(c1Got.size()), 32'd2);
    checkOutput("rst no residual on c2", 32'(c2Got.size()), 32'd3);
`ifdef FIFO_ARB_RX_STATS_EN
    checkOutput("rst c1_pkts after reset", 32'(c1_pkts), 32'd1);
`endif

    // Randomised packets with random full and empty on every cycle
    clearCapture();
    expQ1.delete();
    expQ2.delete();
    npk1 = 0;
    npk2 = 0;
`ifdef FIFO_ARB_RX_STATS_EN
    base1 = c1_pkts;
    base2 = c2_pkts;
`endif
    for (int p = 0; p < 247; p++) begin
      hdr = 8'($urandom_range(0, 255));
      srcQ.push_back(hdr);
      if (hdr[7]) begin expQ2.push_back(hdr); npk2++; end
      else        begin expQ1.push_back(hdr); npk1++; end
      for (int j = 0; j < int'(hdr[6:4]); j++) begin
        pay = 8'($urandom_range(0, 255));
        srcQ.push_back(pay);
        if (hdr[7]) expQ2.push_back(pay);
        else        expQ1.push_back(pay);
      end
    end
    fifo_rdempty = 1'b0;
    randMode = 1'b1;
    runUntil(expQ1.size(), expQ2.size(), 20000, "rand");
    randMode = 1'b0;
    c1_wrfull = 1'b0;
    c2_wrfull = 1'b0;
    repeat (8) stepCycle();
    err1 = 0;
    err2 = 0;
    for (int i = 0; i < expQ1.size(); i++) if (gotAt(1, i) !== {24'd0, expQ1[i]}) err1++;
    for (int i = 0; i < expQ2.size(); i++) if (gotAt(2, i) !== {24'd0, expQ2[i]}) err2++;
    checkOutput("rand c1 word errors", 32'(err1), 32'd0);
    checkOutput("rand c2 word errors", 32'(err2), 32'd0);
    checkOutput("rand c1 count", 32'(c1Got.size()), 32'(expQ1.size()));
    checkOutput("rand c2 count", 32'(c2Got.size()), 32'(expQ2.size()));
`ifdef FIFO_ARB_RX_STATS_EN
    checkOutput("rand c1_pkts delta", 32'(16'(c1_pkts - base1)), 32'(npk1));
    checkOutput("rand c2_pkts delta", 32'(16'(c2_pkts - base2)), 32'(npk2));
    checkOutput("rand pkts total", 32'(16'(c1_pkts - base1) + 16'(c2_pkts - base2)), 32'd247);
`else
    checkOutput("rand packet split", 32'(npk1 + npk2), 32'd247);
`endif

    // Protocol rules watched on every cycle of the whole run
    checkOutput("both wren high cycles", 32'(bothErr), 32'd0);
    checkOutput("wren while full cycles", 32'(fullErr), 32'd0);
    checkOutput("rden while empty cycles", 32'(emptyErr), 32'd0);
    checkOutput("reads past end of input", 32'(underflowErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
